// File: rtl/poly_horner_seq_if.sv
// Handshake, ROM and MAC-operand bundle for the Horner sequencer.
// master = surrounding environment (source, ROM, MAC, sink); slave = sequencer.
interface poly_horner_seq_if #(
  parameter int DATA_WIDTH = 16,
  parameter int SEG_BITS   = 4,
  parameter int ADDR_WIDTH = 7
);
  logic                  in_valid;
  logic                  in_ready;
  logic [SEG_BITS-1:0]   seg_idx;
  logic [DATA_WIDTH-1:0] x_in;
  logic [ADDR_WIDTH-1:0] coef_addr;
  logic [DATA_WIDTH-1:0] coef_data;
  logic [DATA_WIDTH-1:0] mac_d;
  logic [DATA_WIDTH-1:0] mac_p;
  logic [DATA_WIDTH-1:0] mac_coef;
  logic [DATA_WIDTH-1:0] mac_p_out;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] y_out;
  logic                  busy;

  modport master (
    output in_valid, seg_idx, x_in, coef_data, mac_p_out, out_ready,
    input  in_ready, coef_addr, mac_d, mac_p, mac_coef, out_valid, y_out, busy
  );

  modport slave (
    input  in_valid, seg_idx, x_in, coef_data, mac_p_out, out_ready,
    output in_ready, coef_addr, mac_d, mac_p, mac_coef, out_valid, y_out, busy
  );
endinterface

// File: rtl/poly_horner_seq.sv
// Horner-rule sequencer sharing one external MAC; result ORDER+2 cycles after accept.
// One evaluation in flight: in_ready only in IDLE, y_out held until out_ready.
module poly_horner_seq #(
  parameter int DATA_WIDTH = 16,
  parameter int ORDER      = 3,
  parameter int SEG_BITS   = 4,
  parameter int ADDR_WIDTH = 7
) (
  input logic               clk,
  input logic               rst,
  poly_horner_seq_if.slave  bus
);
  localparam int K_WIDTH = $clog2(ORDER + 1);
  localparam logic [ADDR_WIDTH-1:0] STRIDE = ADDR_WIDTH'(ORDER + 1);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_MAC, S_DONE} state_t;

  state_t                state_q;
  logic [DATA_WIDTH-1:0] x_q, p_q, y_q;
  logic [DATA_WIDTH-1:0] d_hold_q, p_hold_q, c_hold_q;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [K_WIDTH-1:0]    k_q;
  logic                  in_ready_q, out_valid_q, busy_q;
  logic [ADDR_WIDTH-1:0] seg_base;
  logic [ADDR_WIDTH-1:0] coef_addr_d;

  assign seg_base = ADDR_WIDTH'(bus.seg_idx) * STRIDE;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      x_q         <= '0;
      p_q         <= '0;
      y_q         <= '0;
      d_hold_q    <= '0;
      p_hold_q    <= '0;
      c_hold_q    <= '0;
      base_q      <= '0;
      k_q         <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.in_valid) begin
            x_q        <= bus.x_in;
            base_q     <= seg_base;
            k_q        <= K_WIDTH'(ORDER - 1);
            state_q    <= S_FETCH;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        S_FETCH: begin
          p_q     <= bus.coef_data;
          state_q <= S_MAC;
        end
        S_MAC: begin
          p_q      <= bus.mac_p_out;
          // Snapshot operands so the MAC inputs stay frozen once the sequence ends.
          d_hold_q <= x_q;
          p_hold_q <= p_q;
          c_hold_q <= bus.coef_data;
          if (k_q == '0) begin
            y_q         <= bus.mac_p_out;
            state_q     <= S_DONE;
            out_valid_q <= 1'b1;
          end else begin
            k_q <= k_q - K_WIDTH'(1);
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // The ROM has one cycle of read latency, so the address always leads the use by a cycle.
  always_comb begin
    coef_addr_d = '0;
    case (state_q)
      S_IDLE:  if (bus.in_valid) coef_addr_d = seg_base + ADDR_WIDTH'(ORDER);
      S_FETCH: coef_addr_d = base_q + ADDR_WIDTH'(k_q);
      S_MAC: begin
        if (k_q != '0) coef_addr_d = base_q + ADDR_WIDTH'(k_q) - ADDR_WIDTH'(1);
        else           coef_addr_d = base_q;
      end
      default: coef_addr_d = base_q;
    endcase
  end

  assign bus.coef_addr = coef_addr_d;
  assign bus.mac_d     = (state_q == S_MAC) ? x_q           : d_hold_q;
  assign bus.mac_p     = (state_q == S_MAC) ? p_q           : p_hold_q;
  assign bus.mac_coef  = (state_q == S_MAC) ? bus.coef_data : c_hold_q;
  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.y_out     = y_q;
endmodule

// File: tb/tb_poly_horner_seq.sv
// Bench for poly_horner_seq: 1-cycle ROM, Q2.14 MAC and a plain Horner golden model.
module tb_poly_horner_seq;
  localparam int DW    = 16;
  localparam int ORDER = 3;
  localparam int SB    = 4;
  localparam int AW    = 7;
  localparam int NCOEF = ORDER + 1;
  localparam int NSEG  = 1 << SB;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc_cnt  = 0;
  logic [DW-1:0] rom [0:NSEG*NCOEF-1];

  poly_horner_seq_if #(.DATA_WIDTH(DW), .SEG_BITS(SB), .ADDR_WIDTH(AW)) bus_if ();

  poly_horner_seq #(.DATA_WIDTH(DW), .ORDER(ORDER), .SEG_BITS(SB), .ADDR_WIDTH(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Q2.14 multiply-accumulate: (d*p) >> 14 + coef, wrapped to 16 bits.
  function automatic logic [DW-1:0] mac_fn(input logic [DW-1:0] d, input logic [DW-1:0] p,
                                           input logic [DW-1:0] c);
    logic signed [31:0] prod;
    prod = 32'($signed(d)) * 32'($signed(p));
    return DW'(prod >>> 14) + c;
  endfunction

  always @(posedge clk) bus_if.coef_data <= rom[bus_if.coef_addr];
  always_comb bus_if.mac_p_out = mac_fn(bus_if.mac_d, bus_if.mac_p, bus_if.mac_coef);

  function automatic logic [DW-1:0] horner(input int seg, input logic [DW-1:0] x);
    logic [DW-1:0] p;
    p = rom[seg*NCOEF + ORDER];
    for (int k = ORDER - 1; k >= 0; k--) p = mac_fn(x, p, rom[seg*NCOEF + k]);
    return p;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Entered and left at negedge+1 with the DUT idle, so calls run back-to-back.
  task automatic run_req(input int seg, input logic [DW-1:0] x, input int hold,
                         input bit stray, input bit chk_addr, output int acc_cyc);
    logic [DW-1:0] exp_y;
    logic [DW-1:0] y_seen;
    int cyc;
    exp_y = horner(seg, x);
    bus_if.seg_idx   = SB'(seg);
    bus_if.x_in      = x;
    bus_if.in_valid  = 1'b1;
    bus_if.out_ready = (hold == 0);
    acc_cyc = cyc_cnt;
    check_eq("accept_ready", 32'(bus_if.in_ready), 32'd1);
    for (cyc = 0; cyc < 20; cyc++) begin
      if (cyc > 0) begin
        @(negedge clk);
        bus_if.in_valid = stray;
        bus_if.seg_idx  = SB'($urandom);
        bus_if.x_in     = DW'($urandom);
      end
      #1;
      if (chk_addr && cyc <= ORDER)
        check_eq($sformatf("addr_c%0d", cyc), 32'(bus_if.coef_addr), 32'(seg*NCOEF + ORDER - cyc));
      if (bus_if.out_valid) break;
    end
    check_eq("latency", 32'(cyc), 32'(ORDER + 2));
    check_eq("y_out", 32'(bus_if.y_out), 32'(exp_y));
    y_seen = bus_if.y_out;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      #1;
      check_eq("hold_valid", 32'(bus_if.out_valid), 32'd1);
      check_eq("hold_in_ready", 32'(bus_if.in_ready), 32'd0);
      check_eq("hold_y", 32'(bus_if.y_out), 32'(y_seen));
    end
    bus_if.out_ready = 1'b1;
    bus_if.in_valid  = 1'b0;
    @(negedge clk);
    #1;
    check_eq("idle_after_done", 32'({bus_if.in_ready, bus_if.out_valid, bus_if.busy}), 32'b100);
  endtask

  initial begin
    int acc, prev_acc, seg;
    logic [DW-1:0] x;
    rst = 1'b1;
    bus_if.in_valid  = 1'b0;
    bus_if.out_ready = 1'b0;
    bus_if.seg_idx   = '0;
    bus_if.x_in      = '0;
    for (int i = 0; i < NSEG*NCOEF; i++) rom[i] = DW'($urandom_range(0, 16'h3fff)) - 16'h2000;
    rom[2*NCOEF+3] = 16'h0000; rom[2*NCOEF+2] = 16'h0000;
    rom[2*NCOEF+1] = 16'h2000; rom[2*NCOEF+0] = 16'h1000;
    for (int k = 0; k < NCOEF; k++) rom[15*NCOEF + k] = 16'h1000;

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("rst_in_ready", 32'(bus_if.in_ready), 32'd1);
    check_eq("rst_out_valid", 32'(bus_if.out_valid), 32'd0);
    check_eq("rst_busy", 32'(bus_if.busy), 32'd0);
    check_eq("rst_y", 32'(bus_if.y_out), 32'd0);
    check_eq("rst_addr", 32'(bus_if.coef_addr), 32'd0);

    run_req(2, 16'h2000, 0, 1'b0, 1'b1, acc);
    check_eq("seg2_y_const", 32'(bus_if.y_out), 32'h2000);
    run_req(2, 16'h2000, 4, 1'b1, 1'b0, acc);
    run_req(15, 16'h0000, 0, 1'b0, 1'b1, acc);
    check_eq("seg15_y_const", 32'(bus_if.y_out), 32'h1000);

    // Abort in MAC with k=1: accept cycle, FETCH, MAC k=2, then reset during MAC k=1.
    bus_if.seg_idx  = SB'(5);
    bus_if.x_in     = 16'h1234;
    bus_if.in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      bus_if.in_valid = 1'b0;
    end
    #1;
    check_eq("pre_abort_busy", 32'(bus_if.busy), 32'd1);
    rst = 1'b1;
    #1;
    check_eq("abort_state", 32'({bus_if.in_ready, bus_if.out_valid, bus_if.busy}), 32'b100);
    check_eq("abort_y", 32'(bus_if.y_out), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (ORDER + 3) begin
      @(negedge clk);
      #1;
      check_eq("abort_no_valid", 32'(bus_if.out_valid), 32'd0);
    end
    run_req(5, 16'h1234, 0, 1'b0, 1'b1, acc);

    prev_acc = -1;
    for (int n = 0; n < 40; n++) begin
      seg = int'($urandom_range(0, NSEG - 1));
      x   = DW'($urandom);
      run_req(seg, x, 0, n[0], 1'b0, acc);
      if (prev_acc >= 0) check_eq("accept_interval", 32'(acc - prev_acc), 32'(ORDER + 3));
      prev_acc = acc;
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
